l2_responder: RTL and testbench
===============================

L2_RESPONDER -- requirements
Module: l2_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, default 3, L2 access cycles (>=1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  L1-side request present.
REQ-006 SHALL have port req_ready  output  1  FIFO can accept a request.
REQ-007 SHALL have port req_op  input  2  l2_op_t: L2_READ=0, L2_WRITE=1, L2_RFO=2, L2_RETURN=3.
REQ-008 SHALL have port req_addr  input  32  line address.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-011 SHALL have port rsp_op  output  2  echoed op of the served request.
REQ-012 SHALL have port rsp_addr  output  32  echoed address.
REQ-013 SHALL have port rsp_snoop  output  2  snoop_result_t: HIT=0, HITM=1, NOHIT=2.
REQ-014 SHALL have ports read_count and write_count  output  32 each  accepted-request counters.

Function
REQ-015 SHALL accept a request on a rising edge iff req_valid && req_ready; req_ready = !full, combinational from occupancy only.
REQ-016 SHALL NOT accept when full, even if the head is popped in the same cycle.
REQ-017 SHALL run FSM IDLE/WAIT/RESP: IDLE pops head into a holding register when FIFO non-empty, loads cnt=LATENCY-1, goes WAIT.
REQ-018 SHALL, in WAIT, decrement cnt each cycle and go RESP on the edge where cnt==0.
REQ-019 SHALL assert rsp_valid only in RESP, with rsp_op/rsp_addr/rsp_snoop stable until rsp_ready is sampled high, then return to IDLE.
REQ-020 SHALL give rsp_valid high LATENCY+1 cycles after the accepting edge when IDLE and FIFO empty; back-to-back service without a gap cycle is not required.
REQ-021 SHALL derive rsp_snoop from rsp_addr[1:0]: 00->HIT, 01->HITM, 1x->NOHIT.
REQ-022 SHALL increment read_count on accepted L2_READ or L2_RFO and write_count on accepted L2_WRITE or L2_RETURN, saturating at 32'hFFFF_FFFF.
REQ-023 SHALL serve requests in strict arrival order; wrap-around of FIFO pointers SHALL be transparent.
REQ-024 SHALL allow a push and a pop in the same cycle when not full, with unchanged occupancy.

Reset
REQ-025 SHALL, while rst=1, clear FIFO, set FSM IDLE and cnt=0, and drive req_ready=1, rsp_valid=0, rsp_op=0, rsp_addr=0, rsp_snoop=HIT, and both counters to 0.
REQ-026 SHALL drop any queued or in-flight request on reset mid-operation; no response follows reset release.

Configuration
REQ-027 SHALL, with L2_RESP_TRACE_EN defined, $display on each response handshake "Read from L2 <%h>", "Write to L2 <%h>", "RFO from L2 <%h>" or "Return data to L2 <%h>" using rsp_addr.
REQ-028 SHALL, without L2_RESP_TRACE_EN, print nothing; cycle behaviour SHALL be identical in both builds.

Structure
REQ-029 SHALL take l2_op_t and snoop_result_t from my_struct_package.
REQ-030 SHALL implement the queue as sub-module l2_req_fifo (DEPTH, push/pop, full/empty, 34-bit entry).

Verification
REQ-031 Reset, then READ 0x984DE132 with rsp_ready=1 -> rsp_valid 4 cycles after accept, rsp_snoop=NOHIT, read_count=1.
REQ-032 Push 4 requests with rsp_ready=0 -> req_ready=0 after 4th; 5th held off; order preserved on drain.
REQ-033 WRITE 0x116DE12D then RETURN 0x100DE130 -> snoop HITM then HIT, write_count=2.
REQ-034 Hold rsp_ready=0 for 10 cycles in RESP -> outputs stable, no advance; release -> IDLE next edge.
REQ-035 Assert rst mid-WAIT with 2 queued -> all outputs at reset values, no response after release.
REQ-036 Push while popping at occupancy 3, 12 wrapping requests -> no loss, FIFO order intact.

Source files
------------

// File: rtl/my_struct_package.sv
// rtl/my_struct_package.sv - shared L2 request/response types and snoop decode
package my_struct_package;

  typedef enum logic [1:0] {
    L2_READ   = 2'd0,
    L2_WRITE  = 2'd1,
    L2_RFO    = 2'd2,
    L2_RETURN = 2'd3
  } l2_op_t;

  typedef enum logic [1:0] {
    HIT   = 2'd0,
    HITM  = 2'd1,
    NOHIT = 2'd2
  } snoop_result_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } l2_state_t;

  localparam int REQ_W = 34;

  // Snoop outcome is modelled from the low line-address bits.
  function automatic snoop_result_t snoop_of(input logic [1:0] lo);
    if (lo[1]) return NOHIT;
    else if (lo[0]) return HITM;
    else return HIT;
  endfunction

endpackage

// File: rtl/l2_req_fifo.sv
// rtl/l2_req_fifo.sv - request queue, DEPTH entries of {op, addr}, head visible combinationally
module l2_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates full from empty when the index bits match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/l2_responder.sv
// rtl/l2_responder.sv - queued L2 responder with fixed access latency; L2_RESP_TRACE_EN adds response trace
module l2_responder
  import my_struct_package::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_op,
  output logic [31:0] rsp_addr,
  output logic [1:0]  rsp_snoop,
  output logic [31:0] read_count,
  output logic [31:0] write_count
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  l2_state_t        state;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [REQ_W-1:0] head;
  l2_op_t           op_in;

  assign op_in     = l2_op_t'(req_op);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state == ST_IDLE) && !empty;

  l2_req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({req_op, req_addr}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // Popped request lands directly in the response registers and stays there until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_op    <= 2'd0;
      rsp_addr  <= 32'd0;
      rsp_snoop <= HIT;
    end else begin
      case (state)
        ST_IDLE: if (!empty) begin
          rsp_op    <= head[33:32];
          rsp_addr  <= head[31:0];
          rsp_snoop <= snoop_of(head[1:0]);
          cnt       <= CW'(LATENCY - 1);
          state     <= ST_WAIT;
        end
        ST_WAIT: if (cnt == '0) begin
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        ST_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_count  <= 32'd0;
      write_count <= 32'd0;
    end else if (push) begin
      if (op_in == L2_READ || op_in == L2_RFO) begin
        if (read_count != 32'hFFFF_FFFF) read_count <= read_count + 32'd1;
      end else begin
        if (write_count != 32'hFFFF_FFFF) write_count <= write_count + 32'd1;
      end
    end
  end

`ifdef L2_RESP_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      case (l2_op_t'(rsp_op))
        L2_READ:  $display("Read from L2 <%h>", rsp_addr);
        L2_WRITE: $display("Write to L2 <%h>", rsp_addr);
        L2_RFO:   $display("RFO from L2 <%h>", rsp_addr);
        default:  $display("Return data to L2 <%h>", rsp_addr);
      endcase
    end
  end
`else
`endif

endmodule

// File: tb/tb_l2_responder.sv
// tb/tb_l2_responder.sv - scoreboard bench for l2_responder with directed vectors
module tb_l2_responder;

  localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_RFO = 2'd2, OP_RETURN = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_addr = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_snoop;
  logic [31:0] read_count;
  logic [31:0] write_count;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [1:0]  snoop;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_rd = 0;
  logic [31:0] m_wr = 0;

  l2_responder dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_op      (rsp_op),
    .rsp_addr    (rsp_addr),
    .rsp_snoop   (rsp_snoop),
    .read_count  (read_count),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_snoop(input logic [31:0] a);
    case (a[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [1:0] op, input logic [31:0] addr);
    int b = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    while (!req_ready && b < 100) begin
      tick();
      b++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: req_ready stuck 0 for addr %h", addr);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back('{op, addr, exp_snoop(addr)});
    if (op == OP_READ || op == OP_RFO) m_rd++;
    else m_wr++;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int b = 0;
    while (!rsp_valid && b < 100) begin
      tick();
      b++;
    end
    check("wait_rsp_valid", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 400) begin
      tick();
      b++;
    end
    check("drain_left", exp_q.size(), 32'd0);
    tick();
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_op", {30'd0, rsp_op}, 32'd0);
    check("rst_rsp_addr", rsp_addr, 32'd0);
    check("rst_rsp_snoop", {30'd0, rsp_snoop}, 32'd0);
    check("rst_read_count", read_count, 32'd0);
    check("rst_write_count", write_count, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_values();
    exp_q.delete();
    m_rd = 0;
    m_wr = 0;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: compares every handshake against the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got addr %h, expected no response", rsp_addr);
        end else begin
          e = exp_q.pop_front();
          check("rsp_op", {30'd0, rsp_op}, {30'd0, e.op});
          check("rsp_addr", rsp_addr, e.addr);
          check("rsp_snoop", {30'd0, rsp_snoop}, {30'd0, e.snoop});
        end
      end
    end
  end

  logic [31:0] wrap_addr [12] = '{32'h0000_1000, 32'h0000_2001, 32'h0000_3002, 32'h0000_4003,
                                  32'h0000_5004, 32'h0000_6005, 32'h0000_7006, 32'h0000_8007,
                                  32'h0000_9008, 32'h0000_A009, 32'h0000_B00A, 32'h0000_C00B};

  initial begin
    #1;
    check_reset_values();
    tick();
    tick();
    rst = 1'b0;

    // Single read: response exactly LATENCY+1 cycles after the accept edge.
    rsp_ready = 1'b1;
    push_req(OP_READ, 32'h984D_E132);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("lat_early_valid", {31'd0, rsp_valid}, 32'd0);
    end
    tick();
    check("lat_valid", {31'd0, rsp_valid}, 32'd1);
    check("lat_snoop_nohit", {30'd0, rsp_snoop}, 32'd2);
    check("read_count_1", read_count, 32'd1);
    wait_drain();

    // Fill: one request held in RESP, four more fill the FIFO, a fifth is held off.
    rsp_ready = 1'b0;
    push_req(OP_READ, 32'h0000_0100);
    wait_rsp();
    push_req(OP_WRITE, 32'h0000_0201);
    push_req(OP_RFO, 32'h0000_0302);
    push_req(OP_RETURN, 32'h0000_0403);
    push_req(OP_READ, 32'h0000_0500);
    check("full_req_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1;
    req_op    = OP_WRITE;
    req_addr  = 32'h0000_0601;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_req_ready", {31'd0, req_ready}, 32'd0);
      check("held_write_count", write_count, m_wr);
    end
    rsp_ready = 1'b1;
    push_req(OP_WRITE, 32'h0000_0601);
    wait_drain();
    check("fill_read_count", read_count, m_rd);
    check("fill_write_count", write_count, m_wr);

    // Write then return after a fresh reset.
    do_reset();
    push_req(OP_WRITE, 32'h116D_E12D);
    push_req(OP_RETURN, 32'h100D_E130);
    wait_drain();
    check("wr_write_count_2", write_count, 32'd2);
    check("wr_read_count_0", read_count, 32'd0);

    // Back-pressure in RESP: outputs frozen, queued request does not advance.
    rsp_ready = 1'b0;
    push_req(OP_READ, 32'h0000_A001);
    push_req(OP_RFO, 32'h0000_B002);
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_addr", rsp_addr, 32'h0000_A001);
      check("stall_op", {30'd0, rsp_op}, 32'd0);
      check("stall_snoop", {30'd0, rsp_snoop}, 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    check("release_idle", {31'd0, rsp_valid}, 32'd0);
    wait_drain();

    // Reset mid-WAIT with two requests queued.
    rsp_ready = 1'b0;
    push_req(OP_READ, 32'h0000_C000);
    push_req(OP_WRITE, 32'h0000_C101);
    push_req(OP_RFO, 32'h0000_C202);
    rst = 1'b1;
    #1;
    check_reset_values();
    exp_q.delete();
    m_rd = 0;
    m_wr = 0;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Push coinciding with pop at occupancy 3; twelve requests wrap the pointers.
    rsp_ready = 1'b0;
    push_req(OP_READ, 32'h0000_0A00);
    wait_rsp();
    push_req(OP_WRITE, 32'h0000_0B01);
    push_req(OP_RFO, 32'h0000_0C02);
    push_req(OP_RETURN, 32'h0000_0D03);
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_rsp();
      tick();
      check("occ3_req_ready", {31'd0, req_ready}, 32'd1);
      push_req(2'(i % 4), wrap_addr[i]);
    end
    wait_drain();
    check("wrap_read_count", read_count, m_rd);
    check("wrap_write_count", write_count, m_wr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
